// File: rtl/cpu_pio_pkg.sv
// Shared constants for the Nios CPU-bus PIO blocks: register word addresses and edge-capture modes.
package cpu_pio_pkg;

    localparam int unsigned PIO_ADDR_W = 3;
    localparam int unsigned PIO_DATA_W = 32;

    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_DATA    = 3'd0;
    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_DIR     = 3'd1;
    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_IRQMASK = 3'd2;
    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_EDGE    = 3'd3;
    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_SET     = 3'd4;
    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_CLR     = 3'd5;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/cpu_pio_sync.sv
// Parameterised-width two-flop synchroniser for asynchronous inputs; both stages clear on reset.
module cpu_pio_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync0_q;
    logic [WIDTH-1:0] sync1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q <= '0;
            sync1_q <= '0;
        end else begin
            sync0_q <= d_i;
            sync1_q <= sync0_q;
        end
    end

    assign q_o = sync1_q;

endmodule

// File: rtl/cpu_pio_in.sv
// Avalon-MM input PIO: synchronised input level, sticky per-bit edge capture and masked level IRQ.
module cpu_pio_in
    import cpu_pio_pkg::*;
#(
    parameter int unsigned      WIDTH      = 2,
    parameter int unsigned      EDGE_TYPE  = EDGE_RISE,
    parameter logic [WIDTH-1:0] RESET_MASK = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [PIO_ADDR_W-1:0] address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [PIO_DATA_W-1:0] writedata,
    output logic [PIO_DATA_W-1:0] readdata,
    input  logic [WIDTH-1:0]      in_port,
    output logic                  irq
);

    if (EDGE_TYPE > EDGE_ANY || WIDTH < 1 || WIDTH > PIO_DATA_W) begin : g_param_err
        $error("cpu_pio_in: EDGE_TYPE must be 0..2 and WIDTH 1..32");
    end

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync_d_q;
    logic [WIDTH-1:0] sync_d_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] clr;
    logic             wr_strobe;
    logic             wdata_unused;

    cpu_pio_sync #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   (in_port),
        .q_o   (sync1)
    );

    // Only the low WIDTH bits of a write are meaningful.
    assign wdata_unused = ^writedata;

    always_comb begin
        sync_d_d  = sync1;
        mask_d    = mask_q;
        clr       = '0;
        wr_strobe = chipselect && !write_n;

        rise = sync1 & ~sync_d_q;
        fall = ~sync1 & sync_d_q;
        sel  = rise;
        if (EDGE_TYPE == EDGE_FALL) begin
            sel = fall;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            sel = rise | fall;
        end

        if (wr_strobe && address == PIO_ADDR_IRQMASK) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_strobe && address == PIO_ADDR_EDGE) begin
            clr = writedata[WIDTH-1:0];
        end
        // A new edge in the same cycle as a software clear must not be lost.
        edge_d = sel | (edge_q & ~clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_d_q <= '0;
            mask_q   <= RESET_MASK;
            edge_q   <= '0;
        end else begin
            sync_d_q <= sync_d_d;
            mask_q   <= mask_d;
            edge_q   <= edge_d;
        end
    end

    // Zero-wait-state read mux, decoded on address alone.
    always_comb begin
        readdata = '0;
        case (address)
            PIO_ADDR_DATA:    readdata = PIO_DATA_W'(sync1);
            PIO_ADDR_IRQMASK: readdata = PIO_DATA_W'(mask_q);
            PIO_ADDR_EDGE:    readdata = PIO_DATA_W'(edge_q);
            default:          readdata = '0;
        endcase
    end

    assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_cpu_pio_in.sv
// Directed bench for cpu_pio_in: a rising-edge instance and an any-edge instance on a shared bus.
module tb_cpu_pio_in;
    import cpu_pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [1:0]  in_r;
    logic [1:0]  in_a;
    logic [31:0] rd_r;
    logic [31:0] rd_a;
    logic        irq_r;
    logic        irq_a;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    cpu_pio_in #(.WIDTH(2), .EDGE_TYPE(0), .RESET_MASK(2'b00)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_r), .in_port(in_r), .irq(irq_r)
    );

    cpu_pio_in #(.WIDTH(2), .EDGE_TYPE(2), .RESET_MASK(2'b00)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(in_a), .irq(irq_a)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic sel_addr(input logic [2:0] a);
        address = a;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        address = '0; writedata = '0; in_r = '0; in_a = '0;
        step();
        for (int a = 0; a < 8; a++) begin
            sel_addr(3'(a));
            checks++;
            if (rd_r !== 32'h0) begin failures++; $display("FAIL reset_rd_r addr=%0d got=%h exp=%h", a, rd_r, 32'h0); end
            checks++;
            if (rd_a !== 32'h0) begin failures++; $display("FAIL reset_rd_a addr=%0d got=%h exp=%h", a, rd_a, 32'h0); end
        end
        checks++;
        if (irq_r !== 1'b0 || irq_a !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b%b exp=00", irq_r, irq_a); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_rise_latency();
        wr(PIO_ADDR_IRQMASK, 32'h1);
        in_r = 2'b01;
        step();
        sel_addr(PIO_ADDR_DATA);
        checks++;
        if (rd_r !== 32'h0) begin failures++; $display("FAIL data_edge_n got=%h exp=%h", rd_r, 32'h0); end
        step();
        sel_addr(PIO_ADDR_DATA);
        checks++;
        if (rd_r !== 32'h1) begin failures++; $display("FAIL data_edge_n1 got=%h exp=%h", rd_r, 32'h1); end
        sel_addr(PIO_ADDR_EDGE);
        checks++;
        if (rd_r !== 32'h0 || irq_r !== 1'b0) begin failures++; $display("FAIL cap_edge_n1 got=%h irq=%b exp=0 irq=0", rd_r, irq_r); end
        step();
        checks++;
        if (rd_r !== 32'h1) begin failures++; $display("FAIL cap_edge_n2 got=%h exp=%h", rd_r, 32'h1); end
        checks++;
        if (irq_r !== 1'b1) begin failures++; $display("FAIL irq_edge_n2 got=%b exp=1", irq_r); end
        wr(PIO_ADDR_EDGE, 32'h1);
        checks++;
        if (rd_r !== 32'h0 || irq_r !== 1'b0) begin failures++; $display("FAIL w1c got=%h irq=%b exp=0 irq=0", rd_r, irq_r); end
    endtask

    task automatic test_mask_change();
        in_r = 2'b11;
        step();
        step();
        sel_addr(PIO_ADDR_EDGE);
        checks++;
        if (rd_r !== 32'h0) begin failures++; $display("FAIL bit1_n1 got=%h exp=%h", rd_r, 32'h0); end
        step();
        checks++;
        if (rd_r !== 32'h2) begin failures++; $display("FAIL bit1_cap got=%h exp=%h", rd_r, 32'h2); end
        checks++;
        if (irq_r !== 1'b0) begin failures++; $display("FAIL bit1_masked_irq got=%b exp=0", irq_r); end
        wr(PIO_ADDR_IRQMASK, 32'hFFFF_FFFF);
        checks++;
        if (irq_r !== 1'b1) begin failures++; $display("FAIL mask_irq got=%b exp=1", irq_r); end
        sel_addr(PIO_ADDR_IRQMASK);
        checks++;
        if (rd_r !== 32'h3) begin failures++; $display("FAIL mask_upper_zero got=%h exp=%h", rd_r, 32'h3); end
        wr(PIO_ADDR_EDGE, 32'h3);
        sel_addr(PIO_ADDR_EDGE);
        checks++;
        if (rd_r !== 32'h0 || irq_r !== 1'b0) begin failures++; $display("FAIL w1c_both got=%h irq=%b exp=0 irq=0", rd_r, irq_r); end
        wr(PIO_ADDR_DATA, 32'h0);
        sel_addr(PIO_ADDR_DATA);
        checks++;
        if (rd_r !== 32'h3) begin failures++; $display("FAIL data_wr_ignored got=%h exp=%h", rd_r, 32'h3); end
        wr(3'd5, 32'hFFFF_FFFF);
        sel_addr(3'd5);
        checks++;
        if (rd_r !== 32'h0) begin failures++; $display("FAIL unmapped_rd got=%h exp=%h", rd_r, 32'h0); end
        sel_addr(PIO_ADDR_DIR);
        checks++;
        if (rd_r !== 32'h0) begin failures++; $display("FAIL dir_rd got=%h exp=%h", rd_r, 32'h0); end
    endtask

    task automatic test_set_clear_collision();
        in_r = 2'b10;
        step(); step(); step();
        sel_addr(PIO_ADDR_EDGE);
        checks++;
        if (rd_r !== 32'h0) begin failures++; $display("FAIL fall_ignored got=%h exp=%h", rd_r, 32'h0); end
        in_r = 2'b11;
        step();
        step();
        wr(PIO_ADDR_EDGE, 32'h1);
        sel_addr(PIO_ADDR_EDGE);
        checks++;
        if (rd_r !== 32'h1) begin failures++; $display("FAIL set_wins got=%h exp=%h", rd_r, 32'h1); end
        checks++;
        if (irq_r !== 1'b1) begin failures++; $display("FAIL set_wins_irq got=%b exp=1", irq_r); end
        step();
        checks++;
        if (rd_r !== 32'h1) begin failures++; $display("FAIL sticky got=%h exp=%h", rd_r, 32'h1); end
        wr(PIO_ADDR_EDGE, 32'h1);
        checks++;
        if (rd_r !== 32'h0) begin failures++; $display("FAIL collision_clear got=%h exp=%h", rd_r, 32'h0); end
    endtask

    task automatic test_any_edge();
        in_a = 2'b01;
        step(); step(); step();
        sel_addr(PIO_ADDR_EDGE);
        checks++;
        if (rd_a !== 32'h1 || irq_a !== 1'b1) begin failures++; $display("FAIL any_rise got=%h irq=%b exp=1 irq=1", rd_a, irq_a); end
        wr(PIO_ADDR_EDGE, 32'h1);
        checks++;
        if (rd_a !== 32'h0 || irq_a !== 1'b0) begin failures++; $display("FAIL any_clear got=%h irq=%b exp=0 irq=0", rd_a, irq_a); end
        step();
        in_a = 2'b00;
        step();
        step();
        checks++;
        if (rd_a !== 32'h0) begin failures++; $display("FAIL any_fall_early got=%h exp=%h", rd_a, 32'h0); end
        step();
        checks++;
        if (rd_a !== 32'h1 || irq_a !== 1'b1) begin failures++; $display("FAIL any_fall got=%h irq=%b exp=1 irq=1", rd_a, irq_a); end
        wr(PIO_ADDR_EDGE, 32'h1);
    endtask

    task automatic test_reset_mid_pulse();
        in_a = 2'b01;
        step(); step(); step();
        sel_addr(PIO_ADDR_EDGE);
        checks++;
        if (rd_a !== 32'h1) begin failures++; $display("FAIL pre_reset_cap got=%h exp=%h", rd_a, 32'h1); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (rd_a !== 32'h0 || rd_r !== 32'h0) begin failures++; $display("FAIL rst_edge got=%h/%h exp=0/0", rd_a, rd_r); end
        checks++;
        if (irq_a !== 1'b0 || irq_r !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b%b exp=00", irq_a, irq_r); end
        sel_addr(PIO_ADDR_IRQMASK);
        checks++;
        if (rd_a !== 32'h0 || rd_r !== 32'h0) begin failures++; $display("FAIL rst_mask got=%h/%h exp=0/0", rd_a, rd_r); end
        sel_addr(PIO_ADDR_DATA);
        checks++;
        if (rd_a !== 32'h0 || rd_r !== 32'h0) begin failures++; $display("FAIL rst_data got=%h/%h exp=0/0", rd_a, rd_r); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        sel_addr(PIO_ADDR_EDGE);
        step(); step();
        checks++;
        if (rd_a !== 32'h0) begin failures++; $display("FAIL post_rst_early got=%h exp=%h", rd_a, 32'h0); end
        step();
        checks++;
        if (rd_a !== 32'h1 || irq_a !== 1'b0) begin failures++; $display("FAIL post_rst_rise got=%h irq=%b exp=1 irq=0", rd_a, irq_a); end
        checks++;
        if (rd_r !== 32'h3) begin failures++; $display("FAIL post_rst_rise_r got=%h exp=%h", rd_r, 32'h3); end
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_mask_change();
        test_set_clear_collision();
        test_any_edge();
        test_reset_mid_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_pio_in.md
Name: cpu_pio_in

Overview:
- Avalon-MM slave input PIO; the read-side counterpart of the output PIO on the Nios CPU bus.
- Synchronises an external input bus, exposes its level, and latches selected edges per bit.
- Raises a level-sensitive interrupt to the Nios IRQ input for enabled captured edges.
- Sits on the CPU data-master interconnect at 8-word span, zero wait states.

Parameters:
- WIDTH, 2, number of input bits (1..32).
- EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any.
- RESET_MASK, 0, reset value of interrupt mask register (WIDTH bits).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset; all state clears on assertion, release synchronous to clk.
- address  in  3  word address within slave.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from registers, zero wait states.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  level interrupt, active high.

Behaviour:
- Register map (word address):
  - 0 DATA: read-only; synchronised input level.
  - 2 IRQMASK: read/write.
  - 3 EDGECAPTURE: read; write-1-to-clear per bit.
  - Other addresses: read 0, writes ignored. Writes to 0 are ignored.
- readdata: bits above WIDTH are always 0. Read mux is combinational on address only; chipselect is not required for read data.
- wr_strobe = chipselect && !write_n.
- Synchroniser: two-stage flop chain sync0 -> sync1, plus delayed copy sync_d <= sync1. All three reset to 0.
- Latency:
  - in_port change stable before edge N is visible on DATA after edge N+1.
  - The edge is captured in EDGECAPTURE after edge N+2.
  - irq is asserted in the same cycle EDGECAPTURE updates.
- Edge detect per bit:
  - rise = sync1 & ~sync_d
  - fall = ~sync1 & sync_d
  - sel = rise, fall, or rise|fall per EDGE_TYPE.
- EDGECAPTURE next value, per bit: set if sel, else clear if (wr_strobe && address==3 && writedata[i]), else hold.
  - Simultaneous set and clear on the same bit: set wins.
  - Captured bits stay set until cleared by software; further edges have no additional effect (no counting).
- IRQMASK: loaded with writedata[WIDTH-1:0] on wr_strobe at address 2. Reset value is RESET_MASK.
- irq = |(EDGECAPTURE & IRQMASK). Combinational from registers, glitch-free.
  - A mask change affects irq in the cycle after the write edge.
- Reset values: readdata reflects registers (DATA 0, IRQMASK RESET_MASK, EDGECAPTURE 0); irq 0.
- Reset is asynchronous and may land mid-operation:
  - All captured edges are lost.
  - Since sync_d resets to 0, an input held high at reset release produces a rising edge 3 cycles after release. This is intended and documented for software.
- Parameter guard: EDGE_TYPE outside 0..2 is a synthesis/elaboration error.

Decomposition:
- Shared package cpu_pio_pkg holds:
  - address constants PIO_ADDR_DATA=0, PIO_ADDR_DIR=1, PIO_ADDR_IRQMASK=2, PIO_ADDR_EDGE=3, PIO_ADDR_SET=4, PIO_ADDR_CLR=5 (shared with the output PIO);
  - edge-type constants EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- One sub-module, cpu_pio_sync: parameterised-width two-flop synchroniser with asynchronous active-low reset. Reusable by other input blocks.

Test Plan:
- Reset then read addresses 0..7 with in_port=0, RESET_MASK=0 -> all readdata 0, irq 0.
- WIDTH=2, EDGE_TYPE=0, write IRQMASK=2'b01, drive in_port 00->01 before edge N:
  - read DATA=1 after edge N+1;
  - EDGECAPTURE=1 and irq=1 after edge N+2;
  - write 1 to address 3 -> EDGECAPTURE=0, irq=0 next cycle.
- EDGE_TYPE=0, in_port bit1 rising with IRQMASK=01 -> EDGECAPTURE=2'b10, irq stays 0; then write IRQMASK=2'b11 -> irq=1 the cycle after the write.
- Issue write-1-to-clear at address 3 in the same cycle a new rising edge is detected on that bit -> bit remains 1.
- EDGE_TYPE=2, pulse in_port[0] 0->1->0 with 5-cycle width -> captured once (bit set); clear, then the falling edge alone sets it again; assert reset_n low mid-pulse -> all registers 0 immediately, irq 0.
